// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor pipeline.
// Instruction layout: func[3:0], rd[8:4], rs1[13:9], rs2[18:14], imm[24:19]; upper bits unused.
package simple_processor_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_AW     = $clog2(NUM_REGS);
    localparam int FUNC_WIDTH = 4;
    localparam int IMM_WIDTH  = 6;
    localparam int INSTR_WIDTH = 32;

    localparam int FUNC_LSB = 0;
    localparam int RD_LSB   = 4;
    localparam int RS1_LSB  = 9;
    localparam int RS2_LSB  = 14;
    localparam int IMM_LSB  = 19;
    localparam int INSTR_USED = IMM_LSB + IMM_WIDTH;

    typedef enum logic [FUNC_WIDTH-1:0] {
        FUNC_ADD  = 4'h0,
        FUNC_SUB  = 4'h1,
        FUNC_ADDI = 4'h2
    } func_t;

    typedef struct packed {
        func_t                func;
        logic [IMM_WIDTH-1:0] imm;
        logic [REG_AW-1:0]    rd;
        logic [REG_AW-1:0]    rs1;
        logic [REG_AW-1:0]    rs2;
    } decoded_op_t;

    // Undefined func encodings are carried through unchanged so the ALU can see them.
    function automatic decoded_op_t decode_instr(input logic [INSTR_USED-1:0] instr);
        decoded_op_t d;
        d.func = func_t'(instr[FUNC_LSB +: FUNC_WIDTH]);
        d.imm  = instr[IMM_LSB +: IMM_WIDTH];
        d.rd   = instr[RD_LSB +: REG_AW];
        d.rs1  = instr[RS1_LSB +: REG_AW];
        d.rs2  = instr[RS2_LSB +: REG_AW];
        return d;
    endfunction

    function automatic logic is_legal(input func_t f);
        return (f == FUNC_ADD) || (f == FUNC_SUB) || (f == FUNC_ADDI);
    endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous write port.
// x0 reads as zero and ignores writes.
module reg_file
    import simple_processor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [REG_AW-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [REG_AW-1:0]     rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [REG_AW-1:0]     rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: decodes instructions, reads the register file with writeback bypass,
// and holds the result in a single valid/ready output slot feeding the ALU.
module operand_fetch
    import simple_processor_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic                  wb_en_i,
    input  logic [REG_AW-1:0]     wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    output logic [FUNC_WIDTH-1:0] func_o,
    output logic [IMM_WIDTH-1:0]  imm_o,
    output logic [REG_AW-1:0]     rd_addr_o,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output logic                  illegal_o
);

    decoded_op_t           dec;
    logic [DATA_WIDTH-1:0] rf_rs1;
    logic [DATA_WIDTH-1:0] rf_rs2;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;
    logic [REG_AW-1:0]     held_rs1;
    logic [REG_AW-1:0]     held_rs2;
    logic                  accept;
    logic                  wb_live;
    logic                  stalled;
    logic                  unused_instr_bits;

    assign unused_instr_bits = ^instr_i[INSTR_WIDTH-1:INSTR_USED];

    assign dec = decode_instr(instr_i[INSTR_USED-1:0]);

    reg_file u_reg_file (
        .clk       (clk_i),
        .rst       (rst_i),
        .wr_en     (wb_en_i),
        .wr_addr   (wb_addr_i),
        .wr_data   (wb_data_i),
        .rd_addr_a (dec.rs1),
        .rd_data_a (rf_rs1),
        .rd_addr_b (dec.rs2),
        .rd_data_b (rf_rs2)
    );

    assign instr_ready_o = !op_valid_o || op_ready_i;
    assign accept        = instr_valid_i && instr_ready_o;
    assign wb_live       = wb_en_i && (wb_addr_i != '0);
    assign stalled       = op_valid_o && !op_ready_i;

    // A write landing on the same edge has not reached the array yet, so forward it.
    assign fwd_rs1 = (wb_live && (wb_addr_i == dec.rs1)) ? wb_data_i : rf_rs1;
    assign fwd_rs2 = (wb_live && (wb_addr_i == dec.rs2)) ? wb_data_i : rf_rs2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_valid_o <= 1'b0;
            illegal_o  <= 1'b0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            func_o     <= '0;
            imm_o      <= '0;
            rd_addr_o  <= '0;
            held_rs1   <= '0;
            held_rs2   <= '0;
        end else if (accept) begin
            op_valid_o <= 1'b1;
            illegal_o  <= !is_legal(dec.func);
            rs1_data_o <= fwd_rs1;
            rs2_data_o <= fwd_rs2;
            func_o     <= dec.func;
            imm_o      <= dec.imm;
            rd_addr_o  <= dec.rd;
            held_rs1   <= dec.rs1;
            held_rs2   <= dec.rs2;
        end else begin
            if (op_valid_o && op_ready_i) begin
                op_valid_o <= 1'b0;
            end
            // Keep stalled operands coherent with writebacks that arrive after capture.
            if (stalled && wb_live) begin
                if (wb_addr_i == held_rs1) begin
                    rs1_data_o <= wb_data_i;
                end
                if (wb_addr_i == held_rs2) begin
                    rs2_data_o <= wb_data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a per-cycle vector table with hand-computed slot
// contents, followed by a short hand-written stall/refresh sequence.
module tb_operand_fetch;
    import simple_processor_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [3:0]  func_o;
    logic [5:0]  imm_o;
    logic [4:0]  rd_addr_o;
    logic        op_valid_o;
    logic        op_ready_i;
    logic        illegal_o;

    int checks = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    operand_fetch dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .rs1_data_o    (rs1_data_o),
        .rs2_data_o    (rs2_data_o),
        .func_o        (func_o),
        .imm_o         (imm_o),
        .rd_addr_o     (rd_addr_o),
        .op_valid_o    (op_valid_o),
        .op_ready_i    (op_ready_i),
        .illegal_o     (illegal_o)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] instr;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        rdy;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [3:0]  e_func;
        logic [5:0]  e_imm;
        logic [4:0]  e_rd;
        logic        e_ill;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    // Upper bits are set to garbage on purpose; the stage must ignore them.
    function automatic logic [31:0] mk(input logic [3:0] f, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [5:0] imm);
        return {7'h55, imm, rs2, rs1, rd, f};
    endfunction

    task automatic apply(input logic rst, input logic iv, input logic [31:0] instr,
                         input logic wb_en, input logic [4:0] wb_addr,
                         input logic [31:0] wb_data, input logic rdy);
        rst_i         = rst;
        instr_valid_i = iv;
        instr_i       = instr;
        wb_en_i       = wb_en;
        wb_addr_i     = wb_addr;
        wb_data_i     = wb_data;
        op_ready_i    = rdy;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic e_valid, input logic e_ready,
                         input logic [31:0] e_rs1, input logic [31:0] e_rs2,
                         input logic [3:0] e_func, input logic [5:0] e_imm,
                         input logic [4:0] e_rd, input logic e_ill);
        checks++;
        if ({op_valid_o, instr_ready_o, rs1_data_o, rs2_data_o, func_o, imm_o, rd_addr_o, illegal_o} ===
            {e_valid, e_ready, e_rs1, e_rs2, e_func, e_imm, e_rd, e_ill}) begin
            passed++;
        end else begin
            $display("FAIL %s: got valid=%0b ready=%0b rs1=%h rs2=%h func=%h imm=%h rd=%0d ill=%0b, want valid=%0b ready=%0b rs1=%h rs2=%h func=%h imm=%h rd=%0d ill=%0b",
                     name, op_valid_o, instr_ready_o, rs1_data_o, rs2_data_o, func_o, imm_o,
                     rd_addr_o, illegal_o, e_valid, e_ready, e_rs1, e_rs2, e_func, e_imm,
                     e_rd, e_ill);
        end
    endtask

    initial begin
        rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0;
        wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0; op_ready_i = 1'b0;

        //          rst  iv   instr                      wb  addr  data          rdy  val  rdy  rs1           rs2           func  imm    rd  ill
        vecs[0]  = '{1'b1,1'b0,32'h0,                    1'b0,5'd0, 32'h0,       1'b0,1'b0,1'b1,32'h0,        32'h0,        4'h0, 6'h00,5'd0,1'b0};
        vecs[1]  = '{1'b1,1'b1,mk(4'h1,5'd9,5'd1,5'd2,6'h1),1'b1,5'd1,32'h11,   1'b1,1'b0,1'b1,32'h0,        32'h0,        4'h0, 6'h00,5'd0,1'b0};
        vecs[2]  = '{1'b0,1'b1,mk(4'h0,5'd3,5'd1,5'd2,6'h0),1'b0,5'd0,32'h0,    1'b1,1'b1,1'b1,32'h0,        32'h0,        4'h0, 6'h00,5'd3,1'b0};
        vecs[3]  = '{1'b0,1'b0,32'h0,                    1'b1,5'd1, 32'h5,       1'b1,1'b0,1'b1,32'h0,        32'h0,        4'h0, 6'h00,5'd3,1'b0};
        vecs[4]  = '{1'b0,1'b0,32'h0,                    1'b1,5'd2, 32'h7,       1'b1,1'b0,1'b1,32'h0,        32'h0,        4'h0, 6'h00,5'd3,1'b0};
        vecs[5]  = '{1'b0,1'b1,mk(4'h1,5'd3,5'd1,5'd2,6'h0),1'b0,5'd0,32'h0,    1'b1,1'b1,1'b1,32'h5,        32'h7,        4'h1, 6'h00,5'd3,1'b0};
        vecs[6]  = '{1'b0,1'b1,mk(4'h0,5'd5,5'd4,5'd1,6'h0),1'b1,5'd4,32'hDEADBEEF,1'b1,1'b1,1'b1,32'hDEADBEEF,32'h5,       4'h0, 6'h00,5'd5,1'b0};
        vecs[7]  = '{1'b0,1'b0,32'h0,                    1'b1,5'd0, 32'hFFFFFFFF,1'b1,1'b0,1'b1,32'hDEADBEEF,32'h5,        4'h0, 6'h00,5'd5,1'b0};
        vecs[8]  = '{1'b0,1'b1,mk(4'h2,5'd6,5'd0,5'd0,6'h3F),1'b1,5'd0,32'hFFFFFFFF,1'b1,1'b1,1'b1,32'h0,     32'h0,        4'h2, 6'h3F,5'd6,1'b0};
        vecs[9]  = '{1'b0,1'b1,mk(4'h0,5'd7,5'd1,5'd2,6'h0),1'b0,5'd0,32'h0,    1'b1,1'b1,1'b1,32'h5,        32'h7,        4'h0, 6'h00,5'd7,1'b0};
        vecs[10] = '{1'b0,1'b1,mk(4'h1,5'd8,5'd3,5'd3,6'h0),1'b1,5'd2,32'h9,    1'b0,1'b1,1'b0,32'h5,        32'h9,        4'h0, 6'h00,5'd7,1'b0};
        vecs[11] = '{1'b0,1'b1,mk(4'h1,5'd8,5'd2,5'd1,6'h0),1'b0,5'd0,32'h0,    1'b1,1'b1,1'b1,32'h9,        32'h5,        4'h1, 6'h00,5'd8,1'b0};
        vecs[12] = '{1'b0,1'b1,mk(4'hF,5'd9,5'd4,5'd0,6'h15),1'b0,5'd0,32'h0,   1'b1,1'b1,1'b1,32'hDEADBEEF,32'h0,        4'hF, 6'h15,5'd9,1'b1};
        vecs[13] = '{1'b0,1'b1,mk(4'h0,5'd1,5'd1,5'd1,6'h0),1'b1,5'd4,32'h1234, 1'b0,1'b1,1'b0,32'h1234,     32'h0,        4'hF, 6'h15,5'd9,1'b1};
        vecs[14] = '{1'b1,1'b1,mk(4'h0,5'd1,5'd1,5'd1,6'h0),1'b0,5'd0,32'h0,    1'b0,1'b0,1'b1,32'h0,        32'h0,        4'h0, 6'h00,5'd0,1'b0};
        vecs[15] = '{1'b0,1'b1,mk(4'h0,5'd1,5'd1,5'd4,6'h0),1'b0,5'd0,32'h0,    1'b0,1'b1,1'b0,32'h0,        32'h0,        4'h0, 6'h00,5'd1,1'b0};
        vecs[16] = '{1'b0,1'b1,mk(4'h0,5'd2,5'd5,5'd5,6'h0),1'b1,5'd5,32'hA5A5, 1'b1,1'b1,1'b1,32'hA5A5,     32'hA5A5,     4'h0, 6'h00,5'd2,1'b0};
        vecs[17] = '{1'b1,1'b0,32'h0,                    1'b1,5'd6, 32'h77,      1'b1,1'b0,1'b1,32'h0,        32'h0,        4'h0, 6'h00,5'd0,1'b0};
        vecs[18] = '{1'b0,1'b1,mk(4'h1,5'd4,5'd6,5'd5,6'h2),1'b0,5'd0,32'h0,    1'b1,1'b1,1'b1,32'h0,        32'h0,        4'h1, 6'h02,5'd4,1'b0};

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].rst, vecs[i].iv, vecs[i].instr, vecs[i].wb_en, vecs[i].wb_addr,
                  vecs[i].wb_data, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_rs1,
                  vecs[i].e_rs2, vecs[i].e_func, vecs[i].e_imm, vecs[i].e_rd, vecs[i].e_ill);
        end

        // Both operands name x3; a stalled refresh must update both, x0 writes must not touch either.
        apply(1'b0, 1'b1, mk(4'h1, 5'd10, 5'd3, 5'd3, 6'h0A), 1'b0, 5'd0, 32'h0, 1'b1);
        check("dual_load", 1'b1, 1'b1, 32'h0, 32'h0, 4'h1, 6'h0A, 5'd10, 1'b0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 5'd3, 32'h42, 1'b0);
        check("dual_refresh", 1'b1, 1'b0, 32'h42, 32'h42, 4'h1, 6'h0A, 5'd10, 1'b0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 5'd0, 32'h99, 1'b0);
        check("x0_no_refresh", 1'b1, 1'b0, 32'h42, 32'h42, 4'h1, 6'h0A, 5'd10, 1'b0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 5'd7, 32'h99, 1'b0);
        check("other_no_refresh", 1'b1, 1'b0, 32'h42, 32'h42, 4'h1, 6'h0A, 5'd10, 1'b0);
        apply(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        check("drain_hold", 1'b0, 1'b1, 32'h42, 32'h42, 4'h1, 6'h0A, 5'd10, 1'b0);
        apply(1'b0, 1'b1, mk(4'h2, 5'd11, 5'd7, 5'd3, 6'h01), 1'b0, 5'd0, 32'h0, 1'b0);
        check("array_read", 1'b1, 1'b0, 32'h99, 32'h42, 4'h2, 6'h01, 5'd11, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
